matmul_ctrl: RTL and testbench

- Sequencer and compute engine that sits directly in front of the 4x4 matrix memory (16 x 32-bit words per access, one-cycle registered read, write whenever read=0).
- On start it reads matrix A and then matrix B, computes C = A*B one element per cycle, and writes C back in a single 16-word write.
- Owns the memory's read/addr/data ports exclusively while active; a top-level mux hands the ports back to the host while it is idle.

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_dot4.sv | 20 ++
 rtl/matmul_ctrl.sv | 128 ++++++++++++
 tb/tb_matmul_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types, sizes and element packing helper for matmul_ctrl
package mm_pkg;

  localparam int WORD_W    = 32;
  localparam int MAT_N     = 4;
  localparam int MAT_WORDS = MAT_N * MAT_N;
  localparam int MEM_TOP   = 100;
  // A 16-word access starting here still ends on MEM_TOP.
  localparam logic [7:0] MAX_BASE = 8'(MEM_TOP - (MAT_WORDS - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_COMP,
    S_WR
  } state_t;

  function automatic int elem_idx(input int r, input int c);
    return MAT_N * r + c;
  endfunction

endpackage

// File: rtl/mm_dot4.sv
// rtl/mm_dot4.sv - 4-term dot product, products and sum wrapped to WORD_W bits
module mm_dot4
  import mm_pkg::*;
(
  input  logic [MAT_N*WORD_W-1:0] row,
  input  logic [MAT_N*WORD_W-1:0] col,
  output logic [WORD_W-1:0]       dot
);

  logic [WORD_W-1:0] prod [MAT_N];

  always_comb begin
    for (int i = 0; i < MAT_N; i++) begin
      prod[i] = row[i*WORD_W +: WORD_W] * col[i*WORD_W +: WORD_W];
    end
  end

  assign dot = (prod[0] + prod[1]) + (prod[2] + prod[3]);

endmodule

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - reads A and B, computes C = A*B one element per cycle, writes C
module matmul_ctrl
  import mm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   addr_a,
  input  logic [7:0]   addr_b,
  input  logic [7:0]   addr_c,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mem_read,
  output logic [7:0]   mem_addr,
  output logic [511:0] mem_wdata,
  input  logic [511:0] mem_rdata
);

  localparam int MAT_W = MAT_WORDS * WORD_W;

  state_t                  state_q, state_d;
  logic [7:0]              addr_a_q, addr_b_q, addr_c_q;
  logic [3:0]              k_q;
  logic [MAT_W-1:0]        a_q, b_q, c_q;
  logic                    done_q, err_q;
  logic                    bad_addr, accept;
  logic [MAT_N*WORD_W-1:0] row_sel, col_sel;
  logic [WORD_W-1:0]       dot;

  assign bad_addr = (addr_a > MAX_BASE) || (addr_b > MAX_BASE) || (addr_c > MAX_BASE);
  assign accept   = (state_q == S_IDLE) && start && !bad_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // mem_read decodes straight from the state register so it is 1 throughout reset.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    mem_read = 1'b1;
    mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = S_RD_A;
      end
      S_RD_A: begin
        mem_addr = addr_a_q;
        state_d  = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = addr_b_q;
        state_d  = S_CAP_B;
      end
      S_CAP_B: begin
        mem_addr = addr_b_q;
        state_d  = S_COMP;
      end
      S_COMP: begin
        if (k_q == 4'hF) state_d = S_WR;
      end
      S_WR: begin
        mem_read = 1'b0;
        mem_addr = addr_c_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row k[3:2] of A and column k[1:0] of B feed the single dot-product unit.
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int i = 0; i < MAT_N; i++) begin
      row_sel[i*WORD_W +: WORD_W] = a_q[elem_idx(int'(k_q[3:2]), i)*WORD_W +: WORD_W];
      col_sel[i*WORD_W +: WORD_W] = b_q[elem_idx(i, int'(k_q[1:0]))*WORD_W +: WORD_W];
    end
  end

  mm_dot4 u_dot4 (
    .row (row_sel),
    .col (col_sel),
    .dot (dot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_WR);
      err_q  <= (state_q == S_IDLE) && start && bad_addr;
      if (accept) begin
        addr_a_q <= addr_a;
        addr_b_q <= addr_b;
        addr_c_q <= addr_c;
      end
      case (state_q)
        S_RD_B:  a_q <= mem_rdata;
        S_CAP_B: begin
          b_q <= mem_rdata;
          k_q <= '0;
        end
        S_COMP: begin
          c_q[elem_idx(int'(k_q[3:2]), int'(k_q[1:0]))*WORD_W +: WORD_W] <= dot;
          k_q <= k_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign mem_wdata = c_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - self-checking bench for matmul_ctrl with a 16-word matrix memory model
module tb_matmul_ctrl;

  localparam int MAXB   = 85;
  localparam int MEM_SZ = 272;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [7:0]   addr_a, addr_b, addr_c;
  logic         busy, done, err, mem_read;
  logic [7:0]   mem_addr;
  logic [511:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  matmul_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_c    (addr_c),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Matrix memory: registered 16-word read, 16-word write whenever read=0, plus a backdoor.
  logic [31:0] mem [MEM_SZ];
  logic [31:0] img [MEM_SZ];
  logic [31:0] exp_c [16];
  logic        bd_we, bd_clr;
  int          bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int a = 0; a < MEM_SZ; a++) mem[a] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (!mem_read) begin
      for (int j = 0; j < 16; j++) mem[int'(mem_addr) + j] <= mem_wdata[j*32 +: 32];
    end
    if (mem_read) begin
      for (int j = 0; j < 16; j++) mem_rdata[j*32 +: 32] <= mem[int'(mem_addr) + j];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    img[a]  = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // 0 skip, 1 identity, 2 values 1..16, 3 all 2, 4 all 3, 5 rows {1,2,3,4},
  // 6 only [0][0]=FFFFFFFF, 7 only [0][0]=2, 8 random
  task automatic load_kind(input int base, input int kind);
    logic [31:0] v;
    if (kind == 0) return;
    for (int j = 0; j < 16; j++) begin
      case (kind)
        1:       v = (j / 4 == j % 4) ? 32'd1 : 32'd0;
        2:       v = 32'(j + 1);
        3:       v = 32'd2;
        4:       v = 32'd3;
        5:       v = 32'(j % 4 + 1);
        6:       v = (j == 0) ? 32'hFFFF_FFFF : 32'd0;
        7:       v = (j == 0) ? 32'd2 : 32'd0;
        default: v = $urandom;
      endcase
      load_word(base + j, v);
    end
  endtask

  task automatic compute_model(input int aa, input int ab);
    logic [31:0] s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int i = 0; i < 4; i++) s = s + img[aa + 4*r + i] * img[ab + 4*i + c];
        exp_c[4*r + c] = s;
      end
    end
  endtask

  task automatic mem_compare(input string tag);
    int diffs;
    diffs = 0;
    for (int a = 0; a < MEM_SZ; a++) if (mem[a] !== img[a]) diffs++;
    check({tag, "_mem"}, diffs, 0);
  endtask

  // One operation; timeline of {busy,done,err,mem_read} checked for cycles T+1..T+26.
  task automatic run_op(input int aa, input int ab, input int ac, input logic exp_err,
                        input int extra_at, input string tag);
    logic [103:0] got_tl, exp_tl;
    logic [511:0] exp_w;
    got_tl = '0;
    exp_tl = '0;
    exp_w  = '0;
    if (!exp_err) compute_model(aa, ab);
    @(negedge clk);
    addr_a = 8'(aa);
    addr_b = 8'(ab);
    addr_c = 8'(ac);
    start  = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      start = (extra_at != 0) && (n == extra_at - 1);
      if (start) addr_c = 8'((ac >= 40) ? ac - 40 : ac + 40);
      got_tl[4*(n-1) +: 4] = {busy, done, err, mem_read};
      exp_tl[4*(n-1) +: 4] = exp_err ? {1'b0, 1'b0, n == 1, 1'b1}
                                     : {n <= 20, n == 21, 1'b0, n != 20};
    end
    start = 1'b0;
    check({tag, "_ctrl"}, got_tl, exp_tl);
    if (!exp_err) begin
      for (int j = 0; j < 16; j++) begin
        img[ac + j]        = exp_c[j];
        exp_w[j*32 +: 32]  = exp_c[j];
      end
      check({tag, "_wdata"}, mem_wdata, exp_w);
    end
    mem_compare(tag);
  endtask

  // Start an operation and pull rst_n low in cycle T+rn; nothing may be written or signalled.
  task automatic run_reset(input int aa, input int ab, input int ac, input int rn,
                           input string tag);
    int          seen_done;
    logic [74:0] quiet;
    seen_done = 0;
    quiet     = '0;
    @(negedge clk);
    addr_a = 8'(aa);
    addr_b = 8'(ab);
    addr_c = 8'(ac);
    start  = 1'b1;
    for (int n = 1; n <= rn; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done++;
    end
    check({tag, "_pre_read"}, mem_read, rn != 20);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_read"}, mem_read, 1'b1);
    check({tag, "_rst_busy"}, busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rst_wdata"}, mem_wdata, '0);
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      quiet[3*n +: 3] = {busy, done, err};
    end
    check({tag, "_quiet"}, quiet, '0);
    check({tag, "_no_done"}, seen_done, 0);
    mem_compare(tag);
  endtask

  typedef struct {
    int          aa, ab, ac, ka, kb;
    logic        exp_err;
    logic [31:0] c00, c33;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int   aa, ab, ac;
    logic e;

    tbl[0] = '{0, 16, 32, 1, 2, 1'b0, 32'd1, 32'd16};
    tbl[1] = '{0, 16, 32, 3, 4, 1'b0, 32'd24, 32'd24};
    tbl[2] = '{0, 16, 32, 5, 1, 1'b0, 32'd1, 32'd4};
    tbl[3] = '{0, 16, 32, 6, 7, 1'b0, 32'hFFFF_FFFE, 32'd0};
    tbl[4] = '{0, 86, 32, 0, 0, 1'b1, 32'd0, 32'd0};
    tbl[5] = '{85, 85, 85, 2, 0, 1'b0, 32'd90, 32'd600};
    tbl[6] = '{101, 0, 32, 0, 0, 1'b1, 32'd0, 32'd0};
    tbl[7] = '{10, 40, 12, 4, 3, 1'b0, 32'd24, 32'd24};
    tbl[8] = '{0, 16, 200, 0, 0, 1'b1, 32'd0, 32'd0};

    rst_n   = 1'b1;
    start   = 1'b0;
    addr_a  = '0;
    addr_b  = '0;
    addr_c  = '0;
    bd_we   = 1'b0;
    bd_clr  = 1'b0;
    bd_addr = 0;
    bd_data = '0;
    for (int a = 0; a < MEM_SZ; a++) img[a] = '0;

    #3 rst_n = 1'b0;
    @(negedge clk);
    bd_clr = 1'b1;
    @(negedge clk);
    bd_clr = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_read", mem_read, 1'b1);
    check("reset_addr", mem_addr, 8'd0);
    check("reset_wdata", mem_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      load_kind(tbl[v].aa, tbl[v].ka);
      load_kind(tbl[v].ab, tbl[v].kb);
      run_op(tbl[v].aa, tbl[v].ab, tbl[v].ac, tbl[v].exp_err, 0, $sformatf("vec%0d", v));
      if (!tbl[v].exp_err) begin
        check($sformatf("vec%0d_c00", v), mem[tbl[v].ac], tbl[v].c00);
        check($sformatf("vec%0d_c33", v), mem[tbl[v].ac + 15], tbl[v].c33);
      end
    end

    load_kind(0, 8);
    load_kind(16, 8);
    run_op(0, 16, 32, 1'b0, 5, "busy_start");

    load_kind(0, 8);
    load_kind(16, 8);
    run_reset(0, 16, 48, 10, "rst_comp");
    run_op(0, 16, 48, 1'b0, 0, "after_rst_comp");
    load_kind(20, 8);
    load_kind(40, 8);
    run_reset(20, 40, 60, 20, "rst_wr");
    run_op(20, 40, 60, 1'b0, 0, "after_rst_wr");

    for (int t = 0; t < 40; t++) begin
      aa = $urandom_range(0, MAXB);
      ab = $urandom_range(0, MAXB);
      ac = $urandom_range(0, MAXB);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       aa = $urandom_range(MAXB + 1, 255);
          1:       ab = $urandom_range(MAXB + 1, 255);
          default: ac = $urandom_range(MAXB + 1, 255);
        endcase
      end
      e = (aa > MAXB) || (ab > MAXB) || (ac > MAXB);
      if (!e) begin
        load_kind(aa, 8);
        load_kind(ab, 8);
      end
      run_op(aa, ab, ac, e, 0, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
